// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI shift engine.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } spi_state_e;

  localparam logic [7:0] DUMMY_BYTE = 8'hFF;
  localparam logic       MOSI_IDLE  = 1'b1;
  localparam logic [7:0] RX_RESET   = 8'hFF;

  // Shift one MISO bit into the LSB while the MSB leaves towards MOSI.
  function automatic logic [7:0] shift_in(input logic [7:0] sh, input logic bit_in);
    return {sh[6:0], bit_in};
  endfunction

endpackage

// File: rtl/spi_shift_engine_if.sv
// CPU request/data bus plus SPI pins of the shift engine.
// master: requester side (CPU decoder and the SPI slave pin), slave: the engine.
interface spi_shift_engine_if;
  logic       enviar_dato;
  logic       recibir_dato;
  logic [7:0] din;
  logic [7:0] dout;
  logic       oe_n;
  logic       spi_transfer_in_progress;
  logic       spi_clk;
  logic       spi_di;
  logic       spi_do;

  modport master (
    output enviar_dato, recibir_dato, din, spi_do,
    input  dout, oe_n, spi_transfer_in_progress, spi_clk, spi_di
  );

  modport slave (
    input  enviar_dato, recibir_dato, din, spi_do,
    output dout, oe_n, spi_transfer_in_progress, spi_clk, spi_di
  );
endinterface

// File: rtl/spi_req_edge.sv
// Two-input rising-edge detector for the write/read request levels.
module spi_req_edge (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_rise
);

  logic [1:0] r_req_q;

  // Remember last cycle's request levels.
  always_ff @(posedge clk) begin
    if (rst) r_req_q <= '0;
    else     r_req_q <= i_req;
  end

  assign o_rise = i_req & ~r_req_q;

endmodule

// File: rtl/spi_shift_engine.sv
// Byte-wide SPI mode-0 master driven by one-shot CPU write/read requests.
// Build option: define SPI_RXPREFETCH_EN to let a read request start a dummy
// 8'hFF transfer that prefetches the next byte; otherwise reads only gate dout.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = 1
) (
  input logic               clk,
  input logic               rst,
  spi_shift_engine_if.slave bus
);

  localparam int                DIV_W      = $clog2(HALF_PERIOD + 1);
  localparam logic [DIV_W-1:0]  DIV_RELOAD = DIV_W'(HALF_PERIOD - 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_LOW  = LOW;
  localparam logic [1:0] S_HIGH = HIGH;

`ifdef SPI_RXPREFETCH_EN
  localparam logic RD_STARTS = 1'b1;
`else
  localparam logic RD_STARTS = 1'b0;
`endif

  logic [1:0]       r_state;
  logic             r_sclk;
  logic             r_mosi;
  logic [7:0]       r_rx;
  logic [7:0]       r_shift;
  logic [2:0]       r_bitcnt;
  logic [DIV_W-1:0] r_div;

  logic [1:0] w_rise;
  logic       w_start_wr;
  logic       w_start_rd;
  logic       w_start;
  logic [7:0] w_load;

  spi_req_edge u_req_edge (
    .clk    (clk),
    .rst    (rst),
    .i_req  ({bus.recibir_dato, bus.enviar_dato}),
    .o_rise (w_rise)
  );

  // A write edge wins over a simultaneous read edge; both are only honoured in IDLE.
  assign w_start_wr = w_rise[0];
  assign w_start_rd = w_rise[1] & RD_STARTS;
  assign w_start    = (r_state == S_IDLE) & (w_start_wr | w_start_rd);
  assign w_load     = w_start_wr ? bus.din : DUMMY_BYTE;

  // Phase sequencer: IDLE -> (LOW -> HIGH) x 8 -> IDLE, each phase HALF_PERIOD clks.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sclk   <= 1'b0;
      r_mosi   <= MOSI_IDLE;
      r_rx     <= RX_RESET;
      r_bitcnt <= 3'd0;
      r_div    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state  <= S_LOW;
            r_sclk   <= 1'b0;
            r_mosi   <= w_load[7];
            r_bitcnt <= 3'd0;
            r_div    <= DIV_RELOAD;
          end
        end
        S_LOW: begin
          if (r_div == '0) begin
            r_state <= S_HIGH;
            r_sclk  <= 1'b1;
            r_div   <= DIV_RELOAD;
          end else begin
            r_div <= r_div - DIV_W'(1);
          end
        end
        S_HIGH: begin
          if (r_div == '0) begin
            r_sclk <= 1'b0;
            r_div  <= DIV_RELOAD;
            if (r_bitcnt == 3'd7) begin
              r_rx    <= r_shift;
              r_mosi  <= MOSI_IDLE;
              r_state <= S_IDLE;
            end else begin
              r_bitcnt <= r_bitcnt + 3'd1;
              r_mosi   <= r_shift[7];
              r_state  <= S_LOW;
            end
          end else begin
            r_div <= r_div - DIV_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Data shifter: load on start, sample MISO on each rising spi_clk.
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_shift <= w_load;
    end else if (r_state == S_LOW && r_div == '0) begin
      r_shift <= shift_in(r_shift, bus.spi_do);
    end
  end

  assign bus.dout                     = r_rx;
  assign bus.oe_n                     = ~bus.recibir_dato;
  assign bus.spi_transfer_in_progress = (r_state != S_IDLE);
  assign bus.spi_clk                  = r_sclk;
  assign bus.spi_di                   = r_mosi;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Scoreboard bench: two engines (HALF_PERIOD 1 with MISO looped to MOSI,
// HALF_PERIOD 3 with a mode-0 slave model) share the CPU request inputs.
module tb_spi_shift_engine;

`ifdef SPI_RXPREFETCH_EN
  localparam bit PREFETCH = 1'b1;
`else
  localparam bit PREFETCH = 1'b0;
`endif

  typedef struct {
    logic [7:0] mosi;
    logic [7:0] rx;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enviar = 1'b0;
  logic       recibir = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] slave_byte = 8'h00;
  logic [7:0] slave_sh = 8'hFF;
  logic       slave_do = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;
  int xfers[2];
  logic [7:0] model_rx[2];
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  spi_shift_engine_if if0 ();
  spi_shift_engine_if if1 ();

  assign if0.enviar_dato  = enviar;
  assign if0.recibir_dato = recibir;
  assign if0.din          = din;
  assign if0.spi_do       = if0.spi_di;
  assign if1.enviar_dato  = enviar;
  assign if1.recibir_dato = recibir;
  assign if1.din          = din;
  assign if1.spi_do       = slave_do;

  spi_shift_engine #(.HALF_PERIOD(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  spi_shift_engine #(.HALF_PERIOD(3)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  logic       sclk_w[2];
  logic       busy_w[2];
  logic       di_w[2];
  logic       oen_w[2];
  logic [7:0] dout_w[2];
  assign sclk_w[0] = if0.spi_clk;  assign sclk_w[1] = if1.spi_clk;
  assign busy_w[0] = if0.spi_transfer_in_progress;
  assign busy_w[1] = if1.spi_transfer_in_progress;
  assign di_w[0]   = if0.spi_di;   assign di_w[1]   = if1.spi_di;
  assign oen_w[0]  = if0.oe_n;     assign oen_w[1]  = if1.oe_n;
  assign dout_w[0] = if0.dout;     assign dout_w[1] = if1.dout;

  // Mode-0 slave for dut1: first bit valid at transfer start, next bit after each falling spi_clk.
  always @(posedge if1.spi_transfer_in_progress) begin
    slave_sh = slave_byte;
    slave_do = slave_byte[7];
  end
  always @(negedge if1.spi_clk) begin
    slave_sh = {slave_sh[6:0], 1'b1};
    slave_do = slave_sh[7];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int qsize(input int id);
    return (id == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qfront(input int id);
    return (id == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpop(input int id);
    if (id == 0) void'(q0.pop_front());
    else         void'(q1.pop_front());
  endtask

  task automatic push_xfer(input logic [7:0] mosi, input logic [7:0] sb);
    exp_t e;
    e.mosi = mosi; e.rx = mosi;  q0.push_back(e);
    e.mosi = mosi; e.rx = sb;    q1.push_back(e);
    model_rx[0] = mosi;
    model_rx[1] = sb;
  endtask

  // Monitor: watches one engine, pops the expected transfer when busy falls.
  task automatic monitor(input int id, input int hp);
    logic       pb = 1'b0;
    logic       ps = 1'b0;
    int         cyc = 0;
    int         run = 0;
    int         nb = 0;
    int         bad_runs = 0;
    logic [7:0] mo = 8'h00;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (busy_w[id] && !pb) begin
        cyc = 0; run = 0; nb = 0; bad_runs = 0; mo = 8'h00;
        if (qsize(id) == 0) begin
          chk($sformatf("unexpected_xfer%0d", id), 1, 0);
        end else begin
          e = qfront(id);
          chk($sformatf("first_mosi%0d", id), di_w[id], e.mosi[7]);
        end
      end
      if (busy_w[id]) begin
        cyc++;
        if (sclk_w[id] != ps) begin
          if (run != hp) bad_runs++;
          run = 1;
          if (sclk_w[id]) begin
            mo = {mo[6:0], di_w[id]};
            nb++;
          end
        end else begin
          run++;
        end
      end
      if (!busy_w[id] && pb) begin
        if (qsize(id) != 0) begin
          e = qfront(id);
          qpop(id);
          if (!rst) begin
            if (run != hp) bad_runs++;
            xfers[id]++;
            chk($sformatf("busy_cycles%0d", id), cyc, 16 * hp);
            chk($sformatf("mosi_byte%0d", id), mo, e.mosi);
            chk($sformatf("sclk_pulses%0d", id), nb, 8);
            chk($sformatf("phase_len%0d", id), bad_runs, 0);
            chk($sformatf("rx_byte%0d", id), dout_w[id], e.rx);
            chk($sformatf("mosi_idle%0d", id), di_w[id], 1);
            chk($sformatf("sclk_idle%0d", id), sclk_w[id], 0);
          end
        end
      end
      pb = busy_w[id];
      ps = sclk_w[id];
    end
  endtask

  initial monitor(0, 1);
  initial monitor(1, 3);

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy_w[0] && !busy_w[1]) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("idle_timeout", 1, 0);
  endtask

  // One request pulse; the scoreboard learns the expected transfer (if any).
  task automatic issue(input logic wr, input logic rd, input logic [7:0] d, input logic [7:0] sb);
    logic xfer;
    @(posedge clk); #1;
    slave_byte = sb;
    din        = d;
    enviar     = wr;
    recibir    = rd;
    xfer       = wr | (rd & PREFETCH);
    if (rd) begin
      #1;
      chk("oe_n_during_read", oen_w[1], 0);
      chk("bus_during_read0", dout_w[0], model_rx[0]);
      chk("bus_during_read1", dout_w[1], model_rx[1]);
    end
    if (xfer) push_xfer(wr ? d : 8'hFF, sb);
    @(posedge clk); #1;
    enviar  = 1'b0;
    recibir = 1'b0;
    if (rd) begin
      #1;
      chk("oe_n_after_read", oen_w[1], 1);
    end
    if (!xfer) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk("read_no_busy", {busy_w[0], busy_w[1], sclk_w[0], sclk_w[1]}, 4'b0000);
      end
    end
    wait_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0, x1;
    model_rx[0] = 8'hFF;
    model_rx[1] = 8'hFF;
    xfers[0] = 0;
    xfers[1] = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_sclk", {sclk_w[0], sclk_w[1]}, 2'b00);
    chk("rst_mosi", {di_w[0], di_w[1]}, 2'b11);
    chk("rst_busy", {busy_w[0], busy_w[1]}, 2'b00);
    chk("rst_dout", {dout_w[0], dout_w[1]}, 16'hFFFF);
    chk("rst_oe_n", {oen_w[0], oen_w[1]}, 2'b11);
    @(posedge clk); #1;
    rst = 1'b0;

    // Two reads (slave returns 12 then 34), then the directed writes.
    issue(1'b0, 1'b1, 8'h00, 8'h12);
    issue(1'b0, 1'b1, 8'h00, 8'h34);
    issue(1'b1, 1'b0, 8'hA5, 8'($urandom));
    issue(1'b1, 1'b0, 8'h3C, 8'h00);
    issue(1'b1, 1'b1, 8'h5A, 8'hC3);

    // Write held high for 40 clks with an extra edge mid-transfer.
    x0 = xfers[0];
    x1 = xfers[1];
    @(posedge clk); #1;
    din = 8'h96; slave_byte = 8'h69; enviar = 1'b1;
    push_xfer(8'h96, 8'h69);
    repeat (6) @(posedge clk);
    #1; enviar = 1'b0;
    @(posedge clk); #1; enviar = 1'b1;
    repeat (33) @(posedge clk);
    #1; enviar = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);
    chk("held_one_xfer0", xfers[0] - x0, 1);
    chk("held_one_xfer1", xfers[1] - x1, 1);

    // Reset after five bits of 8'hF0 on the slow engine.
    @(posedge clk); #1;
    din = 8'hF0; slave_byte = 8'hAA; enviar = 1'b1;
    push_xfer(8'hF0, 8'hAA);
    @(posedge clk); #1;
    enviar = 1'b0;
    repeat (28) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_sclk", sclk_w[1], 0);
    chk("abort_mosi", di_w[1], 1);
    chk("abort_busy", busy_w[1], 0);
    chk("abort_dout", {dout_w[0], dout_w[1]}, 16'hFFFF);
    model_rx[0] = 8'hFF;
    model_rx[1] = 8'hFF;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_q1_drained", q1.size(), 0);

    // Randomized traffic.
    for (int n = 0; n < 14; n++) begin
      int op;
      op = $urandom_range(0, 3);
      case (op)
        0, 3:    issue(1'b1, 1'b0, 8'($urandom), 8'($urandom));
        1:       issue(1'b0, 1'b1, 8'($urandom), 8'($urandom));
        default: issue(1'b1, 1'b1, 8'($urandom), 8'($urandom));
      endcase
    end

    repeat (4) @(negedge clk);
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
